// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared M-extension funct3 encodings and multiply/divide FSM state encoding
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negate
// Ports:
//   value   operand
//   negate  when high, result is -value, otherwise value
//   result  conditionally negated operand
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M/RV64M multiply/divide unit
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous abort of any in-flight or held operation
//   in_valid, in_ready   request handshake; funct3/op_a/op_b sampled on accept
//   out_valid, out_ready result handshake; result is registered
//   busy                 high while an operation is in CALC or DONE
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_next;

    logic [2:0]      op_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic [CW-1:0]   cnt;
    // Multiplicand for multiplies, divisor for divides (always a magnitude).
    logic [XLEN-1:0] opnd_q;
    // Multiply: {high product, low product / remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*XLEN-1:0] acc;

    logic            accept;
    logic            a_signed, b_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div_in, is_rem_in, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_val;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, mul_val, final_val;
    logic              div_neg;

    assign accept    = in_valid && (state == ST_IDLE) && !flush;
    assign in_ready  = (state == ST_IDLE) && !flush;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // ---------------- accept-time decode ----------------
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            F3_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
            F3_MULHSU:      a_signed = 1'b1;
            F3_DIV, F3_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: ;
            default: ;
        endcase
    end

    assign neg_a = a_signed && op_a[XLEN-1];
    assign neg_b = b_signed && op_b[XLEN-1];

    muldiv_negate #(.W(XLEN)) u_mag_a (.value(op_a), .negate(neg_a), .result(mag_a));
    muldiv_negate #(.W(XLEN)) u_mag_b (.value(op_b), .negate(neg_b), .result(mag_b));

    assign is_div_in = funct3[2];
    assign is_rem_in = (funct3 == F3_REM) || (funct3 == F3_REMU);
    assign div_zero  = is_div_in && (op_b == '0);
    assign div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                       && (op_a == MOST_NEG) && (op_b == '1);
    assign special   = div_zero || div_ovf;

    always_comb begin
        special_val = '0;
        if (div_zero) begin
            special_val = is_rem_in ? op_a : '1;
        end else begin
            special_val = is_rem_in ? '0 : MOST_NEG;
        end
    end

    // ---------------- one iteration ----------------
    always_comb begin
        // Shift-add: conditionally add the multiplicand into the high half,
        // then shift the whole accumulator right; the carry lands in the MSB.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // Restoring divide: the top XLEN+1 bits after the left shift are the
        // trial partial remainder; keep the difference only if it is non-negative.
        div_shift = {acc, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd_q};
        div_next  = div_shift[2*XLEN-1:0];
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
        end

        acc_next = op_q[2] ? div_next : mul_next;
    end

    // ---------------- sign fix-up on the final iteration ----------------
    muldiv_negate #(.W(2*XLEN)) u_prod_fix (
        .value (acc_next),
        .negate(sign_a_q ^ sign_b_q),
        .result(prod_fix)
    );

    assign div_raw = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    // Remainder follows the dividend's sign; quotient follows sign(a) ^ sign(b).
    assign div_neg = op_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q);

    muldiv_negate #(.W(XLEN)) u_div_fix (.value(div_raw), .negate(div_neg), .result(div_fix));

    assign mul_val   = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign final_val = op_q[2] ? div_fix : mul_val;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt      <= '0;
            opnd_q   <= '0;
            acc      <= '0;
            result   <= '0;
        end else if (accept) begin
            op_q     <= funct3;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            cnt      <= CW'(XLEN - 1);
            if (is_div_in) begin
                acc    <= {{XLEN{1'b0}}, mag_a};
                opnd_q <= mag_b;
            end else begin
                acc    <= {{XLEN{1'b0}}, mag_b};
                opnd_q <= mag_a;
            end
            if (special) begin
                result <= special_val;
            end
        end else if ((state == ST_CALC) && !flush) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                result <= final_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int N_RANDOM_CYCLES = 6000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model: the unit holds at most one operation.
    bit          m_inflight = 1'b0;
    int          m_due = 0;
    int          m_acc_cyc = 0;
    bit          m_seen = 1'b0;
    logic [31:0] m_exp = '0;
    bit          m_has_lit = 1'b0;
    logic [31:0] m_lit = '0;
    int          m_lit_delay = 0;

    // Hand-computed expectations attached to the next accepted directed op.
    bit          d_lit_en = 1'b0;
    logic [31:0] d_lit = '0;
    int          d_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        bit ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        ovf = (a == MIN32) && (b == 32'hFFFF_FFFF);
        case (f)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? MIN32 : 32'(ia / ib));
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MIN32 && b == 32'hFFFF_FFFF));
    endfunction

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        bit exp_valid;
        cyc++;
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_result", result, 0);
            m_inflight = 1'b0;
        end else begin
            exp_valid = m_inflight && (cyc >= m_due);
            check("out_valid", out_valid, exp_valid);
            check("busy", busy, m_inflight);
            check("in_ready", in_ready, !m_inflight && !flush);
            if (exp_valid && out_valid) begin
                check("result", result, m_exp);
                if (!m_seen && m_has_lit) begin
                    check("lit_result", result, m_lit);
                    // cycles from the accept cycle to the first cycle with out_valid
                    check("valid_delay", cyc - m_acc_cyc, m_lit_delay);
                end
                m_seen = 1'b1;
            end
            if (flush) begin
                m_inflight = 1'b0;
            end else if (exp_valid && out_ready) begin
                m_inflight = 1'b0;
            end else if (!m_inflight && in_valid) begin
                m_inflight  = 1'b1;
                m_exp       = ref_op(funct3, op_a, op_b);
                m_due       = cyc + (is_special(funct3, op_a, op_b) ? 1 : XLEN + 1);
                m_acc_cyc   = cyc;
                m_seen      = 1'b0;
                m_has_lit   = d_lit_en;
                m_lit       = d_lit;
                m_lit_delay = d_delay;
            end
        end
    end

    task automatic wait_accept(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check("accept_wait", in_ready, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check("idle_wait", busy, 0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int delay);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1; funct3 = f; op_a = a; op_b = b; out_ready = 1'b1;
        d_lit_en = 1'b1; d_lit = lit; d_delay = delay;
        wait_accept(n);
        @(posedge clk);
        #1;
        in_valid = 1'b0; d_lit_en = 1'b0;
        wait_idle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, XLEN + 1);
        run_op(F3_MULH,   MIN32,        MIN32,         32'h4000_0000, XLEN + 1);
        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 1);
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, XLEN + 1);
        run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, XLEN + 1);
        run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, XLEN + 1);
        run_op(F3_DIVU,   32'd100,      32'd7,         32'd14,        XLEN + 1);
        run_op(F3_REMU,   32'd100,      32'd7,         32'd2,         XLEN + 1);
        run_op(F3_DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        run_op(F3_REMU,   32'd5,        32'd0,         32'd5,         1);
        run_op(F3_DIV,    MIN32,        32'hFFFF_FFFF, MIN32,         1);
        run_op(F3_REM,    MIN32,        32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure: result held for 10 cycles, then a back-to-back op.
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd9;
        d_lit_en = 1'b1; d_lit = 32'd111; d_delay = XLEN + 1;
        wait_accept(n);
        @(posedge clk);
        #1;
        in_valid = 1'b0; d_lit_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        check("bp_valid_seen", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_result", result, 32'd111);
            check("bp_hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; funct3 = F3_MUL; op_a = 32'd6; op_b = 32'd7;
        d_lit_en = 1'b1; d_lit = 32'd42; d_delay = XLEN + 1;
        wait_accept(n);
        // departure on the first edge, acceptance possible only from the next cycle
        check("b2b_accept_gap", n, 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0; d_lit_en = 1'b0;
        wait_idle();

        // Flush together with in_valid: nothing accepted.
        @(posedge clk);
        #1;
        in_valid = 1'b1; flush = 1'b1; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd0;
        @(negedge clk);
        check("flush_blocks_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-CALC, after iteration 5: outputs clear without a clock edge.
        @(posedge clk);
        #1;
        in_valid = 1'b1; funct3 = F3_MULHU; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        wait_accept(n);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_result", result, 0);
        check("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Flush mid-CALC: back to idle on the next edge, no result ever.
        @(posedge clk);
        #1;
        in_valid = 1'b1; funct3 = F3_DIV; op_a = 32'hFFFF_0000; op_b = 32'd3;
        wait_accept(n);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", busy, 0);
        check("flush_idle_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < N_RANDOM_CYCLES; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom % 3) != 0;
            funct3    = 3'($urandom % 8);
            op_a      = pick_operand();
            op_b      = pick_operand();
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 128) == 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
